spi_flash_reader: RTL and testbench
===================================

Name: spi_flash_reader

Overview:
Sequencer that drives the existing SPI byte engine (en / wr / rd byte streams) to perform autonomous SPI-NOR flash reads.
- On a start pulse it optionally wakes the flash (0xAB release-power-down, wait tRES).
- It then issues READ 0x03 with a 24-bit address and streams the returned bytes to a valid/ready sink.
- It sits beside the bootloader host path, for example to fetch a user image header, and owns the SPI engine only while busy_o is high.

Parameters:
- WAKE_EN, 1: issue the 0xAB wake sequence before each read (0 = skip it).
- WAKE_CYCLES, 64: clk_i cycles csn stays high after 0xAB before READ (tRES ≥ 3 µs at 16 MHz).
- CS_GAP_CYCLES, 4: minimum cycles en_o stays low between commands and after the final command.
- LEN_W, 16: width of the byte-count port.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: asynchronous active-high reset.
- start_i, in, 1: request pulse; sampled only in IDLE.
- addr_i, in, 24: flash byte address; latched on accepted start.
- len_i, in, LEN_W: number of bytes to read; latched on accepted start.
- abort_i, in, 1: terminates the read early.
- busy_o, out, 1: a transaction is in progress.
- done_o, out, 1: one-cycle pulse at transaction end.
- data_o, out, 8: read byte.
- valid_o, out, 1: data_o is valid.
- ready_i, in, 1: sink accepts data_o.
- en_o, out, 1: SPI engine enable (csn asserted while high).
- wr_data_o, out, 8: byte to SPI engine.
- wr_valid_o, out, 1: wr_data_o is valid.
- wr_ready_i, in, 1: engine accepts wr_data_o.
- rd_data_i, in, 8: byte from SPI engine.
- rd_valid_i, in, 1: rd_data_i is valid.
- rd_ready_o, out, 1: controller accepts rd_data_i.

Behaviour:
- Clock, reset and polarity are fixed: single clock clk_i; reset rst_i is asynchronous and active-high.
- Reset values: busy_o=0, done_o=0, valid_o=0, en_o=0, wr_valid_o=0, rd_ready_o=0, wr_data_o=0x00, state=IDLE, all counters 0. data_o is a combinational copy of rd_data_i (not registered).
- SPI engine contract:
  - While en_o is high and the controller offers write bytes, the engine shifts them out and presents no read data.
  - Once writes stop with en_o still high, the engine clocks dummy bytes and presents MISO bytes on rd_valid_i/rd_ready_o.
  - en_o falling deasserts csn.
- Handshakes: a transfer occurs on a cycle where valid&&ready are both high. wr_data_o/wr_valid_o and valid_o must not change until the transfer completes.
- IDLE:
  - busy_o=0.
  - start_i=1 latches addr_i/len_i and sets busy_o=1 on the next cycle.
  - Next state: WAKE_CMD if WAKE_EN, else RD_CMD.
  - start_i while busy_o=1 is ignored.
- WAKE_CMD: en_o=1, wr_data_o=0xAB, wr_valid_o=1. On wr handshake, go to WAKE_WAIT.
- WAKE_WAIT: en_o=0 for exactly WAKE_CYCLES cycles (down-counter), then go to RD_CMD.
- RD_CMD:
  - en_o=1; sends 4 bytes: 0x03, addr[23:16], addr[15:8], addr[7:0].
  - A 2-bit byte index advances on each wr handshake.
  - After the 4th handshake, go to RD_DATA.
- RD_DATA:
  - en_o=1; valid_o=rd_valid_i; rd_ready_o=ready_i. Zero-cycle pass-through, no buffering.
  - Each handshake decrements the remaining count.
  - When the count reaches 0 (the cycle after the last handshake), go to END_GAP.
- END_GAP:
  - en_o=0 for CS_GAP_CYCLES cycles.
  - Then done_o=1 for one cycle, busy_o=0, go to IDLE.
  - A new start_i is accepted no earlier than the cycle after done_o.
- len_i=0:
  - WAKE_EN=0: RD_CMD and RD_DATA are skipped. IDLE → END_GAP directly, with no SPI activity; done_o follows CS_GAP_CYCLES+1 cycles after start.
  - WAKE_EN=1: the wake sequence still runs, then END_GAP.
- abort_i:
  - In RD_DATA, takes effect the same cycle. A handshake occurring that cycle still completes; valid_o/rd_ready_o go to 0 from the next cycle; go to END_GAP.
  - In WAKE_*/RD_CMD, it is deferred until the current byte handshake completes, then the block goes to END_GAP.
  - In all cases done_o is pulsed.
- Address width: 24 bit, no wrap logic in the controller; flash-internal wrap applies.
- len_i arithmetic: LEN_W-bit down-counter, no underflow, because RD_DATA exits at 0.
- rst_i mid-transaction: en_o drops asynchronously; no done_o pulse; the sink must discard the partial stream.

Decomposition:
- Package spi_flash_pkg:
  - Opcode constants OP_READ=8'h03, OP_RES=8'hAB.
  - State encoding: IDLE, WAKE_CMD, WAKE_WAIT, RD_CMD, RD_DATA, END_GAP.
- One natural sub-module, spi_flash_wait_timer: a loadable down-counter with a zero flag, shared by WAKE_WAIT and END_GAP.
- The SPI engine itself is instantiated by the parent, not inside this block.

Test Plan:
1. WAKE_EN=1, addr=0x028000, len=3, engine model returns 0x11,0x22,0x33, ready_i=1.
   → wr bytes AB | (en low 64 cycles) | 03 02 80 00; data_o 11,22,33; done_o one pulse; busy_o low after.
2. WAKE_EN=0, len=4, ready_i toggling 1,0,1,0.
   → exactly 4 valid_o&ready_i handshakes in order; rd_ready_o tracks ready_i; data held stable while stalled.
3. len=0, WAKE_EN=0.
   → en_o never high; done_o at cycle CS_GAP_CYCLES+1 after start.
4. abort_i asserted after the 2nd of 10 data bytes.
   → exactly 2 (or 3, if abort coincides with a handshake) bytes delivered; en_o low the next cycle; done_o pulses after 4 gap cycles.
5. start_i re-pulsed while busy with addr=0xFFFFFF.
   → ignored; the original address is sent.
6. rst_i asserted during RD_CMD byte 2.
   → en_o, wr_valid_o, busy_o are 0 immediately (asynchronously); no done_o; the next start runs normally.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared constants and state encoding for the SPI-NOR flash read sequencer.
package spi_flash_pkg;

  // SPI-NOR opcodes issued by the sequencer.
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RES  = 8'hAB;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    WAKE_CMD,
    WAKE_WAIT,
    RD_CMD,
    RD_DATA,
    END_GAP
  } state_e;

  // Larger of two integers; sizes the shared wait timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_flash_wait_timer.sv
// Loadable down-counter with a zero flag. Shared by the wake wait and the
// chip-select gap: loading N-1 on state entry makes zero_o rise in the
// N-th cycle spent in the waiting state.
module spi_flash_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] r_cnt;

  // Count down to zero and hold; a load overrides counting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/spi_flash_reader.sv
// Autonomous SPI-NOR read sequencer. Drives the SPI byte engine through an
// optional 0xAB wake-up, then READ 0x03 + 24-bit address, and passes the
// returned bytes straight through to a valid/ready sink. All engine-facing
// outputs are decoded from the state register, so an asynchronous reset
// releases chip select immediately.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter bit WAKE_EN       = 1'b1,
  parameter int WAKE_CYCLES   = 64,
  parameter int CS_GAP_CYCLES = 4,
  parameter int LEN_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [23:0]      addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             en_o,
  output logic [7:0]       wr_data_o,
  output logic             wr_valid_o,
  input  logic             wr_ready_i,
  input  logic [7:0]       rd_data_i,
  input  logic             rd_valid_i,
  output logic             rd_ready_o
);

  localparam int TMR_MAX = max_int(WAKE_CYCLES, CS_GAP_CYCLES);
  localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] WAKE_LOAD = TMR_W'(WAKE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(CS_GAP_CYCLES - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [23:0]      r_addr;
  logic [LEN_W-1:0] r_len;
  logic [1:0]       r_idx;
  logic             r_abort_pend;
  logic             r_done;

  logic             w_accept;
  logic             w_wr_hs;
  logic             w_rd_hs;
  logic             w_abort_now;
  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_val;
  logic             w_tmr_zero;

  // Starts are refused during the done pulse so a new request lands at the
  // earliest on the cycle after done_o.
  assign w_accept    = (r_state == IDLE) && start_i && !r_done;
  assign w_wr_hs     = wr_ready_i && ((r_state == WAKE_CMD) || (r_state == RD_CMD));
  assign w_rd_hs     = rd_valid_i && ready_i && (r_state == RD_DATA);
  assign w_abort_now = abort_i || r_abort_pend;

  spi_flash_wait_timer #(
    .W (TMR_W)
  ) u_wait_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (w_tmr_load),
    .load_val_i (w_tmr_val),
    .zero_o     (w_tmr_zero)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and engine/sink outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a signal
    // unassigned and infers a latch.
    w_state_next = r_state;
    en_o         = 1'b0;
    wr_valid_o   = 1'b0;
    wr_data_o    = 8'h00;
    valid_o      = 1'b0;
    rd_ready_o   = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_val    = GAP_LOAD;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (WAKE_EN) begin
            w_state_next = WAKE_CMD;
          end else if (len_i == '0) begin
            w_state_next = END_GAP;
            w_tmr_load   = 1'b1;
          end else begin
            w_state_next = RD_CMD;
          end
        end
      end

      WAKE_CMD: begin
        en_o       = 1'b1;
        wr_valid_o = 1'b1;
        wr_data_o  = OP_RES;
        if (w_wr_hs) begin
          w_tmr_load = 1'b1;
          if (w_abort_now) begin
            w_state_next = END_GAP;
          end else begin
            w_state_next = WAKE_WAIT;
            w_tmr_val    = WAKE_LOAD;
          end
        end
      end

      WAKE_WAIT: begin
        // No byte is in flight here, so an abort exits at once.
        if (w_abort_now || (w_tmr_zero && (r_len == '0))) begin
          w_state_next = END_GAP;
          w_tmr_load   = 1'b1;
        end else if (w_tmr_zero) begin
          w_state_next = RD_CMD;
        end
      end

      RD_CMD: begin
        en_o       = 1'b1;
        wr_valid_o = 1'b1;
        case (r_idx)
          2'd0:    wr_data_o = OP_READ;
          2'd1:    wr_data_o = r_addr[23:16];
          2'd2:    wr_data_o = r_addr[15:8];
          default: wr_data_o = r_addr[7:0];
        endcase
        if (w_wr_hs) begin
          if (w_abort_now) begin
            w_state_next = END_GAP;
            w_tmr_load   = 1'b1;
          end else if (r_idx == 2'd3) begin
            w_state_next = RD_DATA;
          end
        end
      end

      RD_DATA: begin
        en_o       = 1'b1;
        valid_o    = rd_valid_i;
        rd_ready_o = ready_i;
        if (abort_i || (w_rd_hs && (r_len == LEN_W'(1)))) begin
          w_state_next = END_GAP;
          w_tmr_load   = 1'b1;
        end
      end

      END_GAP: begin
        if (w_tmr_zero) begin
          w_state_next = IDLE;
        end
      end

      default: w_state_next = IDLE;
    endcase
  end

  // Request latch, command byte index, remaining count, abort deferral, done.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr       <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_abort_pend <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= (r_state == END_GAP) && w_tmr_zero;

      if (w_accept) begin
        r_addr <= addr_i;
        r_len  <= len_i;
        r_idx  <= '0;
      end else begin
        if ((r_state == RD_CMD) && w_wr_hs) begin
          r_idx <= r_idx + 2'd1;
        end
        if (w_rd_hs) begin
          r_len <= r_len - 1'b1;
        end
      end

      // An abort during a command byte is held until that byte transfers.
      if (r_state == IDLE) begin
        r_abort_pend <= 1'b0;
      end else if (abort_i && ((r_state == WAKE_CMD) || (r_state == RD_CMD))) begin
        r_abort_pend <= 1'b1;
      end
    end
  end

  assign busy_o = (r_state != IDLE);
  assign done_o = r_done;
  assign data_o = rd_data_i;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader. Two instances (wake enabled and
// disabled) each talk to a behavioural SPI engine + flash model; results are
// compared with expectations computed from the request (address, length).
module tb_spi_flash_reader;

  localparam int NI          = 2;   // 0: WAKE_EN=1, 1: WAKE_EN=0
  localparam int WAKE_CYCLES = 64;
  localparam int CS_GAP      = 4;
  localparam int MAXCYC      = 3000;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i      [NI];
  logic        start_i    [NI];
  logic [23:0] addr_i     [NI];
  logic [15:0] len_i      [NI];
  logic        abort_i    [NI];
  logic        busy_o     [NI];
  logic        done_o     [NI];
  logic [7:0]  data_o     [NI];
  logic        valid_o    [NI];
  logic        ready_i    [NI];
  logic        en_o       [NI];
  logic [7:0]  wr_data_o  [NI];
  logic        wr_valid_o [NI];
  logic        wr_ready_i [NI];
  logic [7:0]  rd_data_i  [NI];
  logic        rd_valid_i [NI];
  logic        rd_ready_o [NI];

  spi_flash_reader #(.WAKE_EN(1'b1), .WAKE_CYCLES(WAKE_CYCLES), .CS_GAP_CYCLES(CS_GAP), .LEN_W(16)) u_dut_w (
    .clk_i(clk_i), .rst_i(rst_i[0]), .start_i(start_i[0]), .addr_i(addr_i[0]), .len_i(len_i[0]),
    .abort_i(abort_i[0]), .busy_o(busy_o[0]), .done_o(done_o[0]), .data_o(data_o[0]),
    .valid_o(valid_o[0]), .ready_i(ready_i[0]), .en_o(en_o[0]), .wr_data_o(wr_data_o[0]),
    .wr_valid_o(wr_valid_o[0]), .wr_ready_i(wr_ready_i[0]), .rd_data_i(rd_data_i[0]),
    .rd_valid_i(rd_valid_i[0]), .rd_ready_o(rd_ready_o[0]));

  spi_flash_reader #(.WAKE_EN(1'b0), .WAKE_CYCLES(WAKE_CYCLES), .CS_GAP_CYCLES(CS_GAP), .LEN_W(16)) u_dut_n (
    .clk_i(clk_i), .rst_i(rst_i[1]), .start_i(start_i[1]), .addr_i(addr_i[1]), .len_i(len_i[1]),
    .abort_i(abort_i[1]), .busy_o(busy_o[1]), .done_o(done_o[1]), .data_o(data_o[1]),
    .valid_o(valid_o[1]), .ready_i(ready_i[1]), .en_o(en_o[1]), .wr_data_o(wr_data_o[1]),
    .wr_valid_o(wr_valid_o[1]), .wr_ready_i(wr_ready_i[1]), .rd_data_i(rd_data_i[1]),
    .rd_valid_i(rd_valid_i[1]), .rd_ready_o(rd_ready_o[1]));

  // Monitor / model state, per instance.
  logic [7:0]  wr_log  [NI][$];
  logic [7:0]  eng_cmd [NI][$];
  logic [7:0]  sink    [NI][$];
  int          eng_idx [NI];
  bit          rd_hs_prev [NI];
  bit          wr_pend [NI];
  logic [7:0]  wr_pend_data [NI];
  int done_cnt [NI], done_cyc [NI], start_cyc [NI], ab_cyc [NI], rd_en_cyc [NI];
  int last_rd_cyc [NI], abort_cyc [NI], en_high_cnt [NI], viol [NI];
  int abort_after [NI], ready_mode [NI];
  bit hs_at_abort [NI], en_after_abort [NI], busy_s1 [NI], abort_fired [NI], tgl [NI];
  bit          start_req [NI];
  logic [23:0] req_addr  [NI];
  logic [15:0] req_len   [NI];

  int cyc   = 0;
  int tid   = 0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Flash contents: a few pinned bytes plus an address hash.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h028000: return 8'h11;
      24'h028001: return 8'h22;
      24'h028002: return 8'h33;
      default:    return ({a[3:0], a[7:4]} + a[15:8]) ^ a[23:16] ^ 8'hC3;
    endcase
  endfunction

  task automatic mon_clear(input int i);
    wr_log[i].delete(); eng_cmd[i].delete(); sink[i].delete();
    eng_idx[i] = 0; rd_hs_prev[i] = 0; wr_pend[i] = 0;
    done_cnt[i] = 0; done_cyc[i] = -1; start_cyc[i] = -1; ab_cyc[i] = -1; rd_en_cyc[i] = -1;
    last_rd_cyc[i] = -1; abort_cyc[i] = -1; en_high_cnt[i] = 0; viol[i] = 0;
    abort_after[i] = -1; ready_mode[i] = 0;
    hs_at_abort[i] = 0; en_after_abort[i] = 1; busy_s1[i] = 0; abort_fired[i] = 0; tgl[i] = 0;
  endtask

  // One clock: drive inputs after the falling edge, then record what the
  // coming rising edge will transfer.
  task automatic cycle();
    @(negedge clk_i);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      start_i[i] = start_req[i];
      if (start_req[i]) begin
        addr_i[i] = req_addr[i];
        len_i[i]  = req_len[i];
      end
      start_req[i] = 1'b0;
      if (abort_after[i] >= 0 && !abort_fired[i] && sink[i].size() == abort_after[i]) begin
        abort_i[i] = 1'b1; abort_fired[i] = 1'b1; abort_cyc[i] = cyc;
      end else begin
        abort_i[i] = 1'b0;
      end
      case (ready_mode[i])
        1:       ready_i[i] = 1'b1;
        2:       begin ready_i[i] = ~tgl[i]; tgl[i] = ~tgl[i]; end
        default: ready_i[i] = ($urandom_range(0, 2) != 0);
      endcase
      wr_ready_i[i] = ($urandom_range(0, 3) != 0);
      if (!en_o[i] || rst_i[i]) begin
        rd_valid_i[i] = 1'b0;
        eng_cmd[i].delete();
        eng_idx[i] = 0;
      end else if (!wr_valid_o[i] && eng_cmd[i].size() >= 4 && eng_cmd[i][0] == 8'h03) begin
        if (!rd_valid_i[i] || rd_hs_prev[i]) rd_valid_i[i] = ($urandom_range(0, 3) != 0);
        rd_data_i[i] = mem_byte({eng_cmd[i][1], eng_cmd[i][2], eng_cmd[i][3]} + 24'(eng_idx[i]));
      end else begin
        rd_valid_i[i] = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      if (rst_i[i]) begin
        wr_pend[i] = 0; rd_hs_prev[i] = 0;
      end else begin
        if (en_o[i]) en_high_cnt[i]++;
        if (done_o[i]) begin done_cnt[i]++; done_cyc[i] = cyc; end
        if (start_i[i] && start_cyc[i] < 0) start_cyc[i] = cyc;
        if (start_cyc[i] >= 0 && cyc == start_cyc[i] + 1) busy_s1[i] = busy_o[i];
        if (abort_cyc[i] >= 0 && cyc == abort_cyc[i] + 1) en_after_abort[i] = en_o[i];
        if (wr_pend[i] && (!wr_valid_o[i] || wr_data_o[i] != wr_pend_data[i])) viol[i]++;
        if (wr_valid_o[i] && !en_o[i]) viol[i]++;
        if (en_o[i] && !wr_valid_o[i]) begin
          if (valid_o[i] !== rd_valid_i[i] || rd_ready_o[i] !== ready_i[i] || data_o[i] !== rd_data_i[i])
            viol[i]++;
        end else if (valid_o[i] || rd_ready_o[i]) begin
          viol[i]++;
        end
        if (en_o[i] && ab_cyc[i] >= 0 && rd_en_cyc[i] < 0 && cyc > ab_cyc[i]) rd_en_cyc[i] = cyc;
        if (wr_valid_o[i] && wr_ready_i[i]) begin
          if (eng_cmd[i].size() == 0 && wr_data_o[i] == 8'hAB && ab_cyc[i] < 0) ab_cyc[i] = cyc;
          wr_log[i].push_back(wr_data_o[i]);
          eng_cmd[i].push_back(wr_data_o[i]);
          wr_pend[i] = 0;
        end else begin
          wr_pend[i] = wr_valid_o[i];
          wr_pend_data[i] = wr_data_o[i];
        end
        rd_hs_prev[i] = rd_valid_i[i] && rd_ready_o[i];
        if (rd_hs_prev[i]) eng_idx[i]++;
        if (valid_o[i] && ready_i[i]) begin
          sink[i].push_back(data_o[i]);
          last_rd_cyc[i] = cyc;
          if (cyc == abort_cyc[i]) hs_at_abort[i] = 1;
        end
      end
    end
  endtask

  // Run one transaction on instance i and compare against the request.
  task automatic do_txn(input int i, input logic [23:0] a, input logic [15:0] l,
                        input int ab_after, input bit repulse, input int mode);
    logic [7:0] exp_wr[$];
    int n_exp;
    int n_chk;
    tid++;
    mon_clear(i);
    abort_after[i] = ab_after;
    ready_mode[i]  = mode;
    req_addr[i] = a; req_len[i] = l; start_req[i] = 1'b1;
    for (int k = 0; k < MAXCYC && done_cnt[i] == 0; k++) begin
      if (repulse && start_cyc[i] >= 0 && cyc == start_cyc[i] + 2) begin
        req_addr[i] = 24'hFFFFFF; req_len[i] = 16'd7; start_req[i] = 1'b1;
      end
      cycle();
    end
    repeat (6) cycle();

    if (i == 0) exp_wr.push_back(8'hAB);
    if (l != 0) begin
      exp_wr.push_back(8'h03); exp_wr.push_back(a[23:16]);
      exp_wr.push_back(a[15:8]); exp_wr.push_back(a[7:0]);
    end
    n_exp = int'(l);
    if (ab_after >= 0 && ab_after + int'(hs_at_abort[i]) < n_exp) n_exp = ab_after + int'(hs_at_abort[i]);

    check($sformatf("t%0d_done_cnt", tid), done_cnt[i], 1);
    check($sformatf("t%0d_busy_after_start", tid), int'(busy_s1[i]), 1);
    check($sformatf("t%0d_busy_end", tid), int'(busy_o[i]), 0);
    check($sformatf("t%0d_handshake_rules", tid), viol[i], 0);
    check($sformatf("t%0d_wr_count", tid), wr_log[i].size(), exp_wr.size());
    n_chk = (wr_log[i].size() < exp_wr.size()) ? wr_log[i].size() : exp_wr.size();
    for (int k = 0; k < n_chk; k++)
      check($sformatf("t%0d_wr%0d", tid, k), int'(wr_log[i][k]), int'(exp_wr[k]));
    check($sformatf("t%0d_rd_count", tid), sink[i].size(), n_exp);
    n_chk = (sink[i].size() < n_exp) ? sink[i].size() : n_exp;
    for (int k = 0; k < n_chk; k++)
      check($sformatf("t%0d_rd%0d", tid, k), int'(sink[i][k]), int'(mem_byte(a + 24'(k))));

    if (i == 1 && l == 0) begin
      check($sformatf("t%0d_len0_en_cycles", tid), en_high_cnt[i], 0);
      check($sformatf("t%0d_len0_done_lat", tid), done_cyc[i] - start_cyc[i], CS_GAP + 1);
    end
    if (i == 0 && ab_after < 0) begin
      if (l != 0) check($sformatf("t%0d_wake_gap", tid), rd_en_cyc[i] - ab_cyc[i] - 1, WAKE_CYCLES);
      else check($sformatf("t%0d_wake_len0_done", tid), done_cyc[i] - ab_cyc[i], WAKE_CYCLES + CS_GAP + 1);
    end
    if (ab_after >= 0) begin
      check($sformatf("t%0d_abort_en_low", tid), int'(en_after_abort[i]), 0);
      check($sformatf("t%0d_abort_done_lat", tid), done_cyc[i] - abort_cyc[i], CS_GAP + 1);
    end else if (l != 0) begin
      check($sformatf("t%0d_end_gap", tid), done_cyc[i] - last_rd_cyc[i], CS_GAP + 1);
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_i[i] = 1'b1; start_i[i] = 0; addr_i[i] = '0; len_i[i] = '0; abort_i[i] = 0;
      ready_i[i] = 0; wr_ready_i[i] = 0; rd_data_i[i] = '0; rd_valid_i[i] = 0;
      start_req[i] = 0; req_addr[i] = '0; req_len[i] = '0;
      mon_clear(i);
    end
    repeat (2) @(negedge clk_i);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst%0d_busy", i), int'(busy_o[i]), 0);
      check($sformatf("rst%0d_done", i), int'(done_o[i]), 0);
      check($sformatf("rst%0d_valid", i), int'(valid_o[i]), 0);
      check($sformatf("rst%0d_en", i), int'(en_o[i]), 0);
      check($sformatf("rst%0d_wr_valid", i), int'(wr_valid_o[i]), 0);
      check($sformatf("rst%0d_rd_ready", i), int'(rd_ready_o[i]), 0);
      check($sformatf("rst%0d_wr_data", i), int'(wr_data_o[i]), 0);
    end
    for (int i = 0; i < NI; i++) rst_i[i] = 1'b0;
    repeat (2) cycle();

    // Wake + read of a known header.
    do_txn(0, 24'h028000, 16'd3, -1, 1'b0, 1);
    // No wake, sink stalling every other cycle.
    do_txn(1, 24'($urandom), 16'd4, -1, 1'b0, 2);
    // Zero length without wake: no SPI activity at all.
    do_txn(1, 24'($urandom), 16'd0, -1, 1'b0, 0);
    // Abort after the 2nd of 10 bytes.
    do_txn(1, 24'($urandom), 16'd10, 2, 1'b0, 0);
    // Restart attempt while busy must be ignored.
    do_txn(1, 24'h123456, 16'd3, -1, 1'b1, 0);

    // Reset in the middle of the READ command.
    tid++;
    mon_clear(0);
    ready_mode[0] = 1;
    req_addr[0] = 24'($urandom); req_len[0] = 16'd5; start_req[0] = 1'b1;
    for (int k = 0; k < MAXCYC && wr_log[0].size() < 3; k++) cycle();
    check("t_rst_reached_rd_cmd", wr_log[0].size(), 3);
    #1 rst_i[0] = 1'b1;
    #1;
    check("t_rst_async_en", int'(en_o[0]), 0);
    check("t_rst_async_wr_valid", int'(wr_valid_o[0]), 0);
    check("t_rst_async_busy", int'(busy_o[0]), 0);
    repeat (3) cycle();
    rst_i[0] = 1'b0;
    repeat (20) cycle();
    check("t_rst_no_done", done_cnt[0], 0);
    do_txn(0, 24'($urandom), 16'd2, -1, 1'b0, 0);

    // Randomized transactions on both instances, plus wake-path edge cases.
    for (int r = 0; r < 8; r++)
      do_txn(r % 2, 24'($urandom), 16'($urandom_range(0, 6)), -1, 1'b0, 0);
    do_txn(0, 24'($urandom), 16'd0, -1, 1'b0, 0);
    do_txn(0, 24'($urandom), 16'd8, 3, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
